// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed driver for an eight-digit common-anode seven-segment
// display. A prescaler divides clk_i down to one digit slot every CLK_DIV
// cycles. A 3-bit index scans the digits 0..7. A frame is one full pass over
// all eight digits.
//
// New values are staged in a pending register. They reach the display only at
// a frame boundary, so a frame never shows a torn mix of two numbers.
//
// Ports
//   clk_i      : single clock, rising edge
//   rst_i      : synchronous active-high reset
//   number_i   : eight hex nibbles, nibble k drives digit k
//   load_i     : write strobe for number_i
//   mask_i     : per-digit enable, 1 = digit on
//   hex_led_o  : segments, active-low, bit 0 = a ... bit 6 = g (registered)
//   hex_sel_o  : digit anodes, active-low, at most one low (registered)
//   frame_o    : one-cycle pulse the cycle after each frame boundary
//
// Optional feature
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : when defined, leading zero digits 7..1
//   are turned off. Digit 0 is never blanked.

module seven_seg_scanner #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] number_i,
  input  logic        load_i,
  input  logic [7:0]  mask_i,
  output logic [6:0]  hex_led_o,
  output logic [7:0]  hex_sel_o,
  output logic        frame_o
);

  localparam int CNT_W = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic [2:0]       idx;
  logic [31:0]      pend_reg;
  logic             pend_flag;
  logic [31:0]      disp_reg;

  logic             tick;
  logic             boundary;
  logic [3:0]       cur_nib;
  logic [7:0]       blank;
  logic             digit_on;
  logic [7:0]       sel_next;
  logic [6:0]       led_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign boundary = tick && (idx == 3'd7);
  assign cur_nib  = disp_reg[{idx, 2'b00} +: 4];

  // Scan downward from digit 7. A digit is blanked while every nibble from
  // it up to digit 7 is zero. Digit 0 is left out so that zero still shows.
  always_comb begin
    blank = '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int k = 7; k >= 1; k--) begin
        zero_run = zero_run & (disp_reg[4*k +: 4] == 4'h0);
        blank[k] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    digit_on = mask_i[idx] & ~blank[idx];
    sel_next = 8'hFF;
    led_next = 7'h7F;
    if (digit_on) begin
      sel_next = ~(8'b1 << idx);
      led_next = seg_decode(cur_nib);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A load that lands exactly on the boundary bypasses the pending stage.
  // Otherwise the newest pending value is promoted at the boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_reg  <= '0;
      pend_flag <= 1'b0;
      disp_reg  <= '0;
    end else begin
      if (load_i) begin
        pend_reg <= number_i;
      end
      if (boundary) begin
        pend_flag <= 1'b0;
        if (load_i) begin
          disp_reg <= number_i;
        end else if (pend_flag) begin
          disp_reg <= pend_reg;
        end
      end else if (load_i) begin
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hex_sel_o <= 8'hFF;
      hex_led_o <= 7'h7F;
      frame_o   <= 1'b0;
    end else begin
      hex_sel_o <= sel_next;
      hex_led_o <= led_next;
      frame_o   <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner with CLK_DIV = 4, which gives
// 32 cycles per frame.
//
// cyc counts the rising edges since reset was released. The first edge
// after release is cyc 0. The output observed after edge cyc belongs to
// slot (cyc/4)%8. frame_o is high after edge cyc when cyc%32 == 31.
//
// exp_disp holds the number expected on the display. A load moves its value
// into exp_disp once the next frame-boundary sample has been taken.

module tb_seven_seg_scanner;

  localparam int CLK_DIV = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] number_i;
  logic        load_i;
  logic [7:0]  mask_i;
  logic [6:0]  hex_led_o;
  logic [7:0]  hex_sel_o;
  logic        frame_o;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc;
  logic [31:0] exp_disp;
  logic [31:0] next_disp;
  logic        next_valid;

  seven_seg_scanner #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .number_i  (number_i),
    .load_i    (load_i),
    .mask_i    (mask_i),
    .hex_led_o (hex_led_o),
    .hex_sel_o (hex_sel_o),
    .frame_o   (frame_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] exp_sel,
                             input logic [6:0] exp_led, input logic exp_frame);
    compared++;
    assert (hex_sel_o === exp_sel) else begin
      mismatched++;
      $error("[TB] FAIL %s.sel cyc=%0d observed=%h expected=%h", tag, cyc, hex_sel_o, exp_sel);
    end
    compared++;
    assert (hex_led_o === exp_led) else begin
      mismatched++;
      $error("[TB] FAIL %s.led cyc=%0d observed=%b expected=%b", tag, cyc, hex_led_o, exp_led);
    end
    compared++;
    assert (frame_o === exp_frame) else begin
      mismatched++;
      $error("[TB] FAIL %s.frame cyc=%0d observed=%b expected=%b", tag, cyc, frame_o, exp_frame);
    end
  endtask

  task automatic resetCycle();
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset", 8'hFF, 7'h7F, 1'b0);
  endtask

  task automatic stepCycle(input string tag);
    int         slot;
    logic       on;
    logic [7:0] onehot;
    logic [7:0] esel;
    logic [6:0] eled;
    logic       efr;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    slot = (cyc / 4) % 8;
    on   = mask_i[slot];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (slot != 0 && (exp_disp >> (4 * slot)) == 32'd0) on = 1'b0;
`endif
    onehot = 8'b1 << slot;
    esel   = on ? ~onehot : 8'hFF;
    eled   = on ? seg_of(exp_disp[4*slot +: 4]) : 7'h7F;
    efr    = ((cyc % 32) == 31);
    checkOutput(tag, esel, eled, efr);
    if (efr && next_valid) begin
      exp_disp   = next_disp;
      next_valid = 1'b0;
    end
  endtask

  task automatic runTo(input string tag, input int target);
    while (cyc < target) stepCycle(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] num);
    load_i     = 1'b1;
    number_i   = num;
    next_disp  = num;
    next_valid = 1'b1;
    stepCycle(tag);
    load_i     = 1'b0;
  endtask

  task automatic releaseReset();
    rst_i      = 1'b0;
    cyc        = -1;
    exp_disp   = 32'd0;
    next_valid = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    load_i     = 1'b0;
    number_i   = 32'd0;
    mask_i     = 8'hFF;
    next_disp  = 32'd0;
    next_valid = 1'b0;
    exp_disp   = 32'd0;
    cyc        = -1;

    repeat (3) resetCycle();
    releaseReset();

    // Idle scan of zeros over two frames.
    runTo("idle", 63);

    // A load in the middle of a frame appears only after the boundary.
    runTo("midload", 69);
    applyStimulus("midload", 32'h89ABCDEF);
    runTo("midload", 127);

    // When two loads arrive in one frame, the later one wins.
    runTo("twoload", 130);
    applyStimulus("twoload", 32'h11111111);
    runTo("twoload", 136);
    applyStimulus("twoload", 32'h22222222);
    runTo("twoload", 191);

    // A load on the boundary cycle itself (cyc 223).
    runTo("bndload", 222);
    applyStimulus("bndload", 32'h12345678);
    runTo("bndload", 255);

    // Mask slots 1 and 3, then re-enable in the middle of slot 3.
    mask_i = 8'b1111_0101;
    runTo("mask", 301);
    mask_i = 8'hFF;
    runTo("mask", 319);

    // Reset mid-frame drops the pending load.
    runTo("rstmid", 329);
    applyStimulus("rstmid", 32'hAAAA5555);
    runTo("rstmid", 335);
    rst_i = 1'b1;
    repeat (2) resetCycle();
    releaseReset();
    runTo("postrst", 40);

    // Leading-zero case. All digits are shown unless blanking is compiled in.
    runTo("lz", 44);
    applyStimulus("lz", 32'h00000A05);
    runTo("lz", 95);
    runTo("lzero", 99);
    applyStimulus("lzero", 32'h00000000);
    runTo("lzero", 159);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, giving the clock cycles per digit slot; legal range 2..2^24.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port number_i, input, 32 bits: eight hex nibbles, where nibble k = number_i[4k+3:4k] drives digit k.
REQ-005 SHALL have port load_i, input, 1 bit: write strobe for number_i.
REQ-006 SHALL have port mask_i, input, 8 bits: per-digit enable; 1 = digit on.
REQ-007 SHALL have port hex_led_o, output, 7 bits: segment bus, active-low, bit 0 = segment a, bit 6 = segment g.
REQ-008 SHALL have port hex_sel_o, output, 8 bits: digit anode select, active-low, at most one bit low.
REQ-009 SHALL have port frame_o, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-010 SHALL contain a prescaler counting 0..CLK_DIV-1 that wraps to 0; tick = (prescaler == CLK_DIV-1).
REQ-011 SHALL hold a 3-bit digit index that advances by 1 on tick and wraps from 7 to 0.
REQ-012 SHALL define a frame boundary as tick with digit index == 7.
REQ-013 SHALL capture number_i into a pending register and set a pending flag on any cycle with load_i=1; a later load before the boundary overwrites the earlier one.
REQ-014 SHALL copy the pending register to the display register and clear the pending flag at a frame boundary when the flag is set; otherwise the display register holds.
REQ-015 SHALL load number_i directly into the display register, and leave the pending flag clear, when load_i=1 coincides with a frame boundary.
REQ-016 SHALL pulse frame_o high for exactly one cycle, the cycle after each frame boundary, whether or not an update occurred.
REQ-017 SHALL drive hex_sel_o and hex_led_o from registers, each equal to the combinational value of the previous cycle's state (1-cycle latency).
REQ-018 SHALL set hex_sel_o = ~(8'b1 << idx) when mask_i[idx]=1; otherwise hex_sel_o = 8'hFF and hex_led_o = 7'b1111111.
REQ-019 SHALL decode nibble idx of the display register as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 SHALL sample mask_i every cycle, so mask changes take effect mid-slot with the same 1-cycle latency.

Reset
REQ-021 SHALL, on any clock edge with rst_i=1, clear the prescaler, digit index, pending register, pending flag and display register to 0.
REQ-022 SHALL, during reset, drive hex_sel_o = 8'hFF, hex_led_o = 7'b1111111 and frame_o = 0.
REQ-023 SHALL discard any pending load when reset is asserted mid-frame; the display shows 00000000 after reset.
REQ-024 SHALL show digit 0 on the first cycle after rst_i falls (mask permitting): hex_sel_o = 8'hFE and hex_led_o = 1000000.

Configuration
REQ-025 SHALL, when macro SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined, blank digit k (k=1..7) when display nibbles k..7 are all zero; the blanked digit has segments off and its anode off.
REQ-026 SHALL never blank digit 0 under the leading-zero rule, so value 0 shows a single "0".
REQ-027 SHALL, without the macro, display all eight digits, including leading zeros, subject only to mask_i.

Verification (CLK_DIV=4)
REQ-028 SHALL cover: reset, mask=FF, no load -> hex_sel_o steps FE,FD,FB,...,7F every 4 cycles, hex_led_o always 1000000, frame_o pulses every 32 cycles.
REQ-029 SHALL cover: load 32'h89ABCDEF mid-frame -> display unchanged until the next boundary; the following frame shows digit0=0001110 (F) through digit7=0000000 (8).
REQ-030 SHALL cover: two loads in one frame (11111111 then 22222222) -> only 22222222 is displayed; load coinciding with a boundary is displayed from the next slot.
REQ-031 SHALL cover: mask=8'b1111_0101 -> hex_sel_o = FF and hex_led_o = 7F during slots 1 and 3; other slots behave normally.
REQ-032 SHALL cover: rst_i pulsed mid-frame with a pending load -> outputs FF/7F during reset, then 00000000 is shown and the pending load is lost.
REQ-033 SHALL cover: with SEVEN_SEG_LEADING_ZERO_BLANK_EN, display 32'h0000_0A05 -> digits 3..7 off, digits 0..2 show 5, 0, A; display 0 -> only digit 0 lit.
